time_seg_scan: RTL

//  - Downstream display stage for the minute/second time counter: takes binary minute and second values (0..59) and drives a
//    4-digit multiplexed 7-segment display as MM.SS.
//  - Scans one digit per slot, snapshots inputs once per frame (no tearing) and blanks between digits (anti-ghosting).

---
 rtl/time_seg_pkg.sv | 42 ++++
 rtl/bin2bcd_2dig.sv | 41 ++++
 rtl/time_seg_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/time_seg_pkg.sv
// Shared definitions for the MM.SS multiplexed 7-segment display driver.
//   NUM_DIG    number of scanned digits
//   SEG_*      active-high {g,f,e,d,c,b,a} glyph patterns
//   seg_of()   BCD digit -> glyph (anything above 9 yields a dash)
//   dig_idx_t  scan position: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens
package time_seg_pkg;

    localparam int unsigned NUM_DIG = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef logic [1:0] dig_idx_t;

    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational 6-bit binary to two BCD digits.
//   value_i    binary value, legal 0..59
//   tens_o     value / 10
//   ones_o     value % 10
//   invalid_o  high when value_i > 59 (tens/ones then meaningless)
module bin2bcd_2dig (
    input  logic [5:0] value_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       invalid_o
);

    logic [3:0] tens;
    logic [3:0] sub_lo;

    always_comb begin
        invalid_o = (value_i > 6'd59);

        if      (value_i >= 6'd50) tens = 4'd5;
        else if (value_i >= 6'd40) tens = 4'd4;
        else if (value_i >= 6'd30) tens = 4'd3;
        else if (value_i >= 6'd20) tens = 4'd2;
        else if (value_i >= 6'd10) tens = 4'd1;
        else                       tens = 4'd0;

        // value - 10*tens always lies in 0..9, so subtracting only the low
        // nibble of 10*tens (mod 16) gives the exact ones digit.
        case (tens)
            4'd0:    sub_lo = 4'h0;  // 0x00
            4'd1:    sub_lo = 4'hA;  // 0x0A
            4'd2:    sub_lo = 4'h4;  // 0x14
            4'd3:    sub_lo = 4'hE;  // 0x1E
            4'd4:    sub_lo = 4'h8;  // 0x28
            default: sub_lo = 4'h2;  // 0x32
        endcase

        tens_o = tens;
        ones_o = value_i[3:0] - sub_lo;
    end

endmodule

// File: rtl/time_seg_scan.sv
// MM.SS driver for a 4-digit multiplexed 7-segment display.
//   InClk      system clock (CLK_HZ)
//   InReset    asynchronous active-low reset
//   InSecond   binary seconds 0..59 (60..63 shown as dashes)
//   InMinute   binary minutes 0..59 (60..63 shown as dashes)
//   OutDigSel  one-hot digit enable: bit0 sec ones .. bit3 min tens
//   OutSeg     {dp,g,f,e,d,c,b,a}
// Inputs are snapshotted once per frame so a frame never mixes two times.
// Each slot starts with BLANK_CYC cycles of all digits off to avoid ghosting.
// Optional macro SEG_COLON_BLINK_EN: digit-2 dp blinks at half-second rate;
// without it the dp is permanently lit.
module time_seg_scan
    import time_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 1_000_000,
    parameter int unsigned DIG_DIV        = 1000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               InClk,
    input  logic               InReset,
    input  logic [5:0]         InSecond,
    input  logic [5:0]         InMinute,
    output logic [NUM_DIG-1:0] OutDigSel,
    output logic [7:0]         OutSeg
);

    localparam int unsigned        DIV_W     = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIG_DIV - 1);
    localparam logic [DIV_W-1:0]   BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [NUM_DIG-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]         SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    if (DIG_DIV <= BLANK_CYC || CLK_HZ < 2) begin : g_bad_cfg
        $error("time_seg_scan: need DIG_DIV > BLANK_CYC and CLK_HZ >= 2");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    dig_idx_t           idx_q, idx_d;
    logic               first_q;
    logic [5:0]         sec_q, min_q;
    logic [NUM_DIG-1:0] dig_q, dig_d;
    logic [7:0]         seg_q, seg_d;
    logic               wrap, snap_en, blink;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
    logic       sec_inv, min_inv;

    bin2bcd_2dig u_sec_bcd (
        .value_i   (sec_q),
        .tens_o    (sec_tens),
        .ones_o    (sec_ones),
        .invalid_o (sec_inv)
    );

    bin2bcd_2dig u_min_bcd (
        .value_i   (min_q),
        .tens_o    (min_tens),
        .ones_o    (min_ones),
        .invalid_o (min_inv)
    );

`ifdef SEG_COLON_BLINK_EN
    localparam int unsigned      HALF_SEC = CLK_HZ / 2;
    localparam int unsigned      HS_W     = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;
    localparam logic [HS_W-1:0]  HS_LAST  = HS_W'(HALF_SEC - 1);

    logic [HS_W-1:0] half_q;
    logic            blink_q;

    always_ff @(posedge InClk or negedge InReset) begin
        if (!InReset) begin
            half_q  <= '0;
            blink_q <= 1'b1;
        end else if (half_q == HS_LAST) begin
            half_q  <= '0;
            blink_q <= ~blink_q;
        end else begin
            half_q  <= half_q + 1'b1;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

    always_comb begin
        wrap    = (div_q == DIV_LAST);
        div_d   = wrap ? '0 : div_q + 1'b1;
        idx_d   = wrap ? idx_q + 1'b1 : idx_q;
        // Capture on the first cycle out of reset and at each 3->0 frame wrap.
        snap_en = first_q || (wrap && (idx_q == 2'd3));
    end

    always_comb begin
        logic [6:0]         pat;
        logic [NUM_DIG-1:0] dig_hi;

        unique case (idx_q)
            2'd0: pat = sec_inv ? SEG_DASH : seg_of(sec_ones);
            2'd1: pat = sec_inv ? SEG_DASH : seg_of(sec_tens);
            2'd2: pat = min_inv ? SEG_DASH : seg_of(min_ones);
            2'd3: pat = min_inv ? SEG_DASH : seg_of(min_tens);
        endcase
        seg_d = {(idx_q == 2'd2) && blink, pat};
        if (SEG_ACTIVE_LOW) seg_d = ~seg_d;

        dig_hi = '0;
        if (div_q >= BLANK_END) dig_hi[idx_q] = 1'b1;
        dig_d = DIG_ACTIVE_LOW ? ~dig_hi : dig_hi;
    end

    always_ff @(posedge InClk or negedge InReset) begin
        if (!InReset) begin
            div_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            sec_q   <= '0;
            min_q   <= '0;
            dig_q   <= DIG_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            if (snap_en) begin
                sec_q <= InSecond;
                min_q <= InMinute;
            end
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    assign OutDigSel = dig_q;
    assign OutSeg    = seg_q;

endmodule
